// File: rtl/cla_updown_counter.sv
// Up/down counter whose next-count adder is a two-level carry-lookahead tree:
// 4-bit lookahead groups feeding a group-level lookahead block.

module cla_updown_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       pg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened in-group carries: no bit waits on its neighbour's carry.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;
  assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
  assign pg  = &p;

endmodule

module cla_updown_counter #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min
);

  localparam int NG = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("cla_updown_counter: WIDTH must be a multiple of 4 in 4..64");
  end

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             sat_reg;
  logic             sat_next;

  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] sum;
  logic             cin;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    pg;
  logic [NG:0]      gc;
  logic             cout;
  logic             at_limit;

  // Increment adds 0 with carry-in 1; decrement adds all-ones with carry-in 0.
  assign opnd = {WIDTH{~up}};
  assign cin  = up;

  genvar gi;
  genvar gj;

  for (gi = 0; gi < NG; gi++) begin : g_grp
    cla_updown_group u_grp (
      .a   (count_reg[4*gi +: 4]),
      .b   (opnd[4*gi +: 4]),
      .cin (gc[gi]),
      .sum (sum[4*gi +: 4]),
      .gg  (gg[gi]),
      .pg  (pg[gi])
    );
  end

  // Group lookahead: carry into group gi is a sum of products over all lower
  // group generates/propagates, so depth stays constant across groups.
  assign gc[0] = cin;
  for (gi = 1; gi <= NG; gi++) begin : g_look
    logic [gi:0] terms;
    for (gj = 0; gj < gi; gj++) begin : g_term
      if (gj == gi - 1) begin : g_last
        assign terms[gj] = gg[gj];
      end else begin : g_mid
        assign terms[gj] = gg[gj] & (&pg[gi-1:gj+1]);
      end
    end
    assign terms[gi] = cin & (&pg[gi-1:0]);
    assign gc[gi]    = |terms;
  end

  // Increment carries out only from all-ones; decrement carries out unless zero.
  assign cout     = gc[NG];
  assign at_limit = up ? cout : ~cout;

  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    sat_next   = 1'b0;
    if (load) begin
      count_next = din;
    end else if (en) begin
      if (at_limit && (SATURATE != 0)) begin
        sat_next = 1'b1;
      end else begin
        count_next = sum;
        wrap_next  = at_limit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
      sat_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
      sat_reg   <= sat_next;
    end
  end

  assign count  = count_reg;
  assign wrap   = wrap_reg;
  assign sat    = sat_reg;
  assign at_max = &count_reg;
  assign at_min = ~|count_reg;

endmodule

// File: tb/tb_cla_updown_counter.sv
// Bench for cla_updown_counter: four instances (16 wrap, 16 saturate, 4 wrap,
// 32 saturate) share stimulus and are checked every cycle against a model.

module tb_cla_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din16 = '0;
  logic [3:0]  din4 = '0;
  logic [31:0] din32 = '0;

  logic [15:0] c0, c1;
  logic [3:0]  c2;
  logic [31:0] c3;
  logic        w0, w1, w2, w3;
  logic        s0, s1, s2, s3;
  logic        mx0, mx1, mx2, mx3;
  logic        mn0, mn1, mn2, mn3;

  int tests = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  cla_updown_counter #(.WIDTH(16), .SATURATE(0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din16),
    .count(c0), .wrap(w0), .sat(s0), .at_max(mx0), .at_min(mn0));
  cla_updown_counter #(.WIDTH(16), .SATURATE(1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din16),
    .count(c1), .wrap(w1), .sat(s1), .at_max(mx1), .at_min(mn1));
  cla_updown_counter #(.WIDTH(4), .SATURATE(0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din4),
    .count(c2), .wrap(w2), .sat(s2), .at_max(mx2), .at_min(mn2));
  cla_updown_counter #(.WIDTH(32), .SATURATE(1)) u_s32 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din32),
    .count(c3), .wrap(w3), .sat(s3), .at_max(mx3), .at_min(mn3));

  // Reference model: plain arithmetic on an unbounded integer, clipped to width.
  int              wid [4] = '{16, 16, 4, 32};
  bit              satm[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  longint unsigned mc  [4] = '{default: 0};
  bit              mw  [4] = '{default: 0};
  bit              ms  [4] = '{default: 0};

  function automatic longint unsigned lim(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint unsigned din_of(input int i);
    case (i)
      2:       return 64'(din4);
      3:       return 64'(din32);
      default: return 64'(din16);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mc[i] <= 0;
        mw[i] <= 1'b0;
        ms[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        longint unsigned nc;
        longint unsigned top;
        bit nw;
        bit ns;
        top = lim(wid[i]);
        nc  = mc[i];
        nw  = 1'b0;
        ns  = 1'b0;
        if (load) begin
          nc = din_of(i) & top;
        end else if (en && up) begin
          if (mc[i] == top) begin
            if (satm[i]) ns = 1'b1;
            else begin nc = 0; nw = 1'b1; end
          end else nc = mc[i] + 1;
        end else if (en && !up) begin
          if (mc[i] == 0) begin
            if (satm[i]) ns = 1'b1;
            else begin nc = top; nw = 1'b1; end
          end else nc = mc[i] - 1;
        end
        mc[i] <= nc;
        mw[i] <= nw;
        ms[i] <= ns;
      end
    end
  end

  task automatic cmp(input int i, input longint unsigned c, input logic w,
                     input logic s, input logic amx, input logic amn);
    bit emx;
    bit emn;
    emx = (mc[i] == lim(wid[i]));
    emn = (mc[i] == 0);
    tests++;
    if (c !== mc[i] || w !== mw[i] || s !== ms[i] || amx !== emx || amn !== emn) begin
      errors++;
      $display("FAIL model_dut%0d t=%0t: got count=%h wrap=%b sat=%b max=%b min=%b, expected count=%h wrap=%b sat=%b max=%b min=%b",
               i, $time, c, w, s, amx, amn, mc[i], mw[i], ms[i], emx, emn);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp(0, 64'(c0), w0, s0, mx0, mn0);
      cmp(1, 64'(c1), w1, s1, mx1, mn1);
      cmp(2, 64'(c2), w2, s2, mx2, mn2);
      cmp(3, 64'(c3), w3, s3, mx3, mn3);
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Called just after a falling edge; returns on the next falling edge.
  task automatic drive(input bit l, input bit e, input bit u, input logic [31:0] d);
    load  = l;
    en    = e;
    up    = u;
    din16 = d[15:0];
    din4  = d[3:0];
    din32 = d;
    @(negedge clk);
    $display("[TB] txn load=%0b en=%0b up=%0b din=%h -> c16=%h w=%b c16s=%h s=%b c4=%h c32=%h",
             l, e, u, d, c0, w0, c1, s1, c2, c3);
  endtask

  logic [15:0] ld_tab[3] = '{16'h0FFF, 16'h00FF, 16'h7FFF};
  logic [15:0] ex_tab[3] = '{16'h1000, 16'h0100, 16'h8000};

  initial begin
    #1;
    chk("rst_count", 64'(c0), 0);
    chk("rst_at_min", 64'(mn0), 1);
    chk("rst_at_max", 64'(mx0), 0);
    chk("rst_wrap", 64'(w0), 0);
    chk("rst_sat", 64'(s1), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h0);
      chk("up_seq", 64'(c0), 64'(i));
      chk("up_seq_wrap", 64'(w0), 0);
      if (i == 1) chk("at_min_drop", 64'(mn0), 0);
    end

    drive(1'b1, 1'b0, 1'b0, 32'hFFFE);
    chk("load_fffe", 64'(c0), 64'hFFFE);
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    chk("reach_max", 64'(c0), 64'hFFFF);
    chk("at_max", 64'(mx0), 1);
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    chk("wrap_to_0", 64'(c0), 0);
    chk("wrap_pulse", 64'(w0), 1);
    chk("sat_hold_max", 64'(c1), 64'hFFFF);
    chk("sat_pulse_max", 64'(s1), 1);
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    chk("after_wrap", 64'(c0), 1);
    chk("wrap_one_cycle", 64'(w0), 0);

    drive(1'b1, 1'b0, 1'b0, 32'h0001);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("sat_down_0", 64'(c1), 0);
    chk("sat_down_nopulse", 64'(s1), 0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("sat_hold_min", 64'(c1), 0);
    chk("sat_pulse_min", 64'(s1), 1);
    chk("sat_no_wrap", 64'(w1), 0);
    chk("underflow_wrap", 64'(c0), 64'hFFFF);
    chk("underflow_pulse", 64'(w0), 1);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("sat_again", 64'(s1), 1);
    chk("down_after_wrap", 64'(c0), 64'hFFFE);

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("hold", 64'(c0), 64'hFFFE);

    drive(1'b1, 1'b1, 1'b0, 32'h1234);
    chk("load_wins", 64'(c0), 64'h1234);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("down_1233", 64'(c0), 64'h1233);

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, {16'h0, ld_tab[k]});
      drive(1'b0, 1'b1, 1'b1, 32'h0);
      chk("carry_sweep", 64'(c0), 64'(ex_tab[k]));
      chk("carry_sweep_w4", 64'(w2), 1);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h1000);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("borrow_sweep", 64'(c0), 64'h0FFF);

    drive(1'b1, 1'b0, 1'b0, 32'h00A4);
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    chk("pre_reset", 64'(c0), 64'h00A5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(c0), 0);
    chk("async_rst_min", 64'(mn0), 1);
    chk("async_rst_c32", 64'(c3), 0);
    @(negedge clk);
    chk("rst_discard_step", 64'(c0), 0);
    en    = 1'b0;
    rst_n = 1'b1;

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] d;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       d = 32'hFFFF_FFFF;
        1:       d = 32'h0;
        2:       d = 32'hFFFF_FFFE;
        default: d = $urandom;
      endcase
      drive(($urandom_range(0, 11) == 0), ($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 1)), d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
